// File: rtl/mbus_sleep_ctrl.sv
// Layer sleep controller: sequences power, clock, isolation and reset of the
// gated layer domain on sleep requests and wake sources, with timed dwell steps.
module mbus_sleep_ctrl #(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                 CLK_EXT,
  input  logic                 RESET,
  input  logic                 SLEEP_REQ,
  input  logic                 WAKEUP_REQ,
  input  logic                 EXTERNAL_INT,
  output logic                 CLR_EXT_INT,
  output logic                 POWER_ON,
  output logic                 RELEASE_CLK,
  output logic                 RELEASE_ISO,
  output logic                 RELEASE_RST,
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] SLEEP_COUNT
);

  localparam logic IO_HOLD    = 1'b1;
  localparam logic IO_RELEASE = 1'b0;
  // A dwell of 0 is treated as 1, so the reload value never underflows.
  localparam logic [7:0] DWELL_LOAD = (STEP_CYCLES > 1) ? 8'(STEP_CYCLES - 1) : 8'd0;

  typedef enum logic [2:0] {
    ASLEEP, WK_PWR, WK_CLK, WK_ISO, AWAKE, SL_RST, SL_ISO, SL_CLK
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] dwell;
  logic       dwell_done;
  logic       wake_src;
  logic       pwr_nxt, clk_nxt, iso_nxt, rst_nxt, clr_nxt;
  logic       count_inc;

  assign dwell_done = (dwell == 8'd0);
  assign wake_src   = WAKEUP_REQ | EXTERNAL_INT;
  assign count_inc  = (state == SL_CLK) && (state_nxt == ASLEEP);

  always_ff @(posedge CLK_EXT) begin
    if (RESET) begin
      state       <= ASLEEP;
      dwell       <= '0;
      POWER_ON    <= IO_HOLD;
      RELEASE_CLK <= IO_HOLD;
      RELEASE_ISO <= IO_HOLD;
      RELEASE_RST <= IO_HOLD;
      CLR_EXT_INT <= 1'b0;
      SLEEP_COUNT <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        dwell <= DWELL_LOAD;
      else if (!dwell_done)
        dwell <= dwell - 8'd1;
      POWER_ON    <= pwr_nxt;
      RELEASE_CLK <= clk_nxt;
      RELEASE_ISO <= iso_nxt;
      RELEASE_RST <= rst_nxt;
      CLR_EXT_INT <= clr_nxt;
      if (count_inc && !(&SLEEP_COUNT))
        SLEEP_COUNT <= SLEEP_COUNT + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ASLEEP:  if (wake_src) state_nxt = WK_PWR;
      WK_PWR:  if (dwell_done) state_nxt = WK_CLK;
      WK_CLK:  if (dwell_done) state_nxt = WK_ISO;
      WK_ISO:  if (dwell_done) state_nxt = AWAKE;
      AWAKE:   if (SLEEP_REQ && !wake_src) state_nxt = SL_RST;
      SL_RST:  if (dwell_done) state_nxt = SL_ISO;
      SL_ISO:  if (dwell_done) state_nxt = SL_CLK;
      SL_CLK:  if (dwell_done) state_nxt = ASLEEP;
      default: state_nxt = ASLEEP;
    endcase
  end

  // Control levels are decoded from the state being entered, so each one
  // registers its change on exactly the edge that enters its state.
  always_comb begin
    pwr_nxt = IO_HOLD;
    clk_nxt = IO_HOLD;
    iso_nxt = IO_HOLD;
    rst_nxt = IO_HOLD;
    case (state_nxt)
      WK_PWR: pwr_nxt = IO_RELEASE;
      WK_CLK: begin
        pwr_nxt = IO_RELEASE;
        clk_nxt = IO_RELEASE;
      end
      WK_ISO: begin
        pwr_nxt = IO_RELEASE;
        clk_nxt = IO_RELEASE;
        iso_nxt = IO_RELEASE;
      end
      AWAKE: begin
        pwr_nxt = IO_RELEASE;
        clk_nxt = IO_RELEASE;
        iso_nxt = IO_RELEASE;
        rst_nxt = IO_RELEASE;
      end
      SL_RST: begin
        pwr_nxt = IO_RELEASE;
        clk_nxt = IO_RELEASE;
        iso_nxt = IO_RELEASE;
      end
      SL_ISO: begin
        pwr_nxt = IO_RELEASE;
        clk_nxt = IO_RELEASE;
      end
      SL_CLK: pwr_nxt = IO_RELEASE;
      default: ;
    endcase
    clr_nxt = (state == ASLEEP) && (state_nxt == WK_PWR);
    BUSY    = !((state == ASLEEP) || (state == AWAKE));
  end

endmodule

// File: tb/tb_mbus_sleep_ctrl.sv
// Bench for mbus_sleep_ctrl: directed vector table on a STEP_CYCLES=4 instance
// plus a timeline reference model checking it and a STEP_CYCLES=0 instance.
module tb_mbus_sleep_ctrl;

  logic CLK_EXT = 1'b0;
  always #5 CLK_EXT = ~CLK_EXT;

  logic RESET = 1'b1, SLEEP_REQ = 1'b0, WAKEUP_REQ = 1'b0, EXTERNAL_INT = 1'b0;
  logic       clr_o [2];
  logic       pwr_o [2];
  logic       clk_o [2];
  logic       iso_o [2];
  logic       rst_o [2];
  logic       busy_o[2];
  logic [7:0] cnt_o [2];

  mbus_sleep_ctrl #(.STEP_CYCLES(4), .CNT_WIDTH(8)) dut (
    .CLK_EXT(CLK_EXT), .RESET(RESET), .SLEEP_REQ(SLEEP_REQ), .WAKEUP_REQ(WAKEUP_REQ),
    .EXTERNAL_INT(EXTERNAL_INT), .CLR_EXT_INT(clr_o[0]), .POWER_ON(pwr_o[0]),
    .RELEASE_CLK(clk_o[0]), .RELEASE_ISO(iso_o[0]), .RELEASE_RST(rst_o[0]),
    .BUSY(busy_o[0]), .SLEEP_COUNT(cnt_o[0]));

  mbus_sleep_ctrl #(.STEP_CYCLES(0), .CNT_WIDTH(8)) dut_s0 (
    .CLK_EXT(CLK_EXT), .RESET(RESET), .SLEEP_REQ(SLEEP_REQ), .WAKEUP_REQ(WAKEUP_REQ),
    .EXTERNAL_INT(EXTERNAL_INT), .CLR_EXT_INT(clr_o[1]), .POWER_ON(pwr_o[1]),
    .RELEASE_CLK(clk_o[1]), .RELEASE_ISO(iso_o[1]), .RELEASE_RST(rst_o[1]),
    .BUSY(busy_o[1]), .SLEEP_COUNT(cnt_o[1]));

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 asleep, 1 powering up, 2 awake, 3 powering down;
  // t counts edges since the sequence began, control levels follow from t/S.
  int unsigned step_s[2] = '{4, 1};
  int mode[2] = '{0, 0};
  int t   [2] = '{0, 0};
  int mcnt[2] = '{0, 0};
  bit mclr[2] = '{1'b0, 1'b0};

  typedef struct {
    int       n;
    bit       r, s, w, e;
    bit [5:0] exp;  // {POWER_ON, RELEASE_CLK, RELEASE_ISO, RELEASE_RST, CLR_EXT_INT, BUSY}
    int       c;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  function automatic bit [5:0] exp_vec(input int k);
    int s;
    bit [3:0] lv;
    s = int'(step_s[k]);
    case (mode[k])
      0:       lv = 4'b1111;
      2:       lv = 4'b0000;
      1:       lv = {1'b0, (t[k] >= s) ? 1'b0 : 1'b1, (t[k] >= 2*s) ? 1'b0 : 1'b1, 1'b1};
      default: lv = {1'b0, (t[k] >= 2*s) ? 1'b1 : 1'b0, (t[k] >= s) ? 1'b1 : 1'b0, 1'b1};
    endcase
    return {lv, mclr[k], (mode[k] == 1 || mode[k] == 3)};
  endfunction

  function automatic bit [5:0] dut_vec(input int k);
    return {pwr_o[k], clk_o[k], iso_o[k], rst_o[k], clr_o[k], busy_o[k]};
  endfunction

  task automatic step();
    @(posedge CLK_EXT);
    for (int k = 0; k < 2; k++) begin
      if (RESET) begin
        mode[k] = 0; t[k] = 0; mcnt[k] = 0; mclr[k] = 1'b0;
      end else begin
        mclr[k] = 1'b0;
        case (mode[k])
          0: if (WAKEUP_REQ || EXTERNAL_INT) begin mode[k] = 1; t[k] = 0; mclr[k] = 1'b1; end
          1: begin t[k]++; if (t[k] == 3*int'(step_s[k])) mode[k] = 2; end
          2: if (SLEEP_REQ && !WAKEUP_REQ && !EXTERNAL_INT) begin mode[k] = 3; t[k] = 0; end
          default: begin
            t[k]++;
            if (t[k] == 3*int'(step_s[k])) begin
              mode[k] = 0;
              if (mcnt[k] < 255) mcnt[k]++;
            end
          end
        endcase
      end
    end
    @(negedge CLK_EXT);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_ctl%0d", k), 32'(dut_vec(k)), 32'(exp_vec(k)));
      chk($sformatf("model_cnt%0d", k), 32'(cnt_o[k]), 32'(mcnt[k]));
    end
  endtask

  task automatic drive(input bit r, input bit s, input bit w, input bit e);
    RESET = r; SLEEP_REQ = s; WAKEUP_REQ = w; EXTERNAL_INT = e;
  endtask

  initial begin
    tbl.push_back('{3, 1,0,0,0, 6'b111100, 0});  // reset held
    tbl.push_back('{1, 0,0,0,1, 6'b011111, 0});  // edge n: POWER_ON, CLR pulse
    tbl.push_back('{1, 0,0,0,0, 6'b011101, 0});
    tbl.push_back('{3, 0,0,0,0, 6'b001101, 0});  // n+4: CLK
    tbl.push_back('{3, 0,0,0,0, 6'b001101, 0});
    tbl.push_back('{1, 0,0,0,0, 6'b000101, 0});  // n+8: ISO
    tbl.push_back('{3, 0,0,0,0, 6'b000101, 0});
    tbl.push_back('{1, 0,0,0,0, 6'b000000, 0});  // n+12: AWAKE
    tbl.push_back('{1, 0,1,0,0, 6'b000101, 0});  // edge m: RST held
    tbl.push_back('{4, 0,0,0,0, 6'b001101, 0});  // m+4: ISO held, dropped request ignored
    tbl.push_back('{4, 0,0,0,0, 6'b011101, 0});  // m+8: CLK held
    tbl.push_back('{3, 0,0,0,0, 6'b011101, 0});
    tbl.push_back('{1, 0,0,0,0, 6'b111100, 1});  // m+12: ASLEEP, count 1
    tbl.push_back('{2, 0,1,0,0, 6'b111100, 1});  // sleep ignored while asleep
    tbl.push_back('{1, 0,0,1,0, 6'b011111, 1});
    tbl.push_back('{11,0,0,0,0, 6'b000101, 1});
    tbl.push_back('{1, 0,0,0,0, 6'b000000, 1});
    tbl.push_back('{3, 0,1,1,0, 6'b000000, 1});  // wake beats sleep
    tbl.push_back('{1, 0,1,0,0, 6'b000101, 1});
    tbl.push_back('{4, 0,0,0,0, 6'b001101, 1});  // SL_ISO entered
    tbl.push_back('{7, 0,0,1,0, 6'b011101, 1});  // wake held, not aborting
    tbl.push_back('{1, 0,0,1,0, 6'b111100, 2});
    tbl.push_back('{1, 0,0,1,0, 6'b011111, 2});  // wake acted on next edge
    tbl.push_back('{12,0,0,0,0, 6'b000000, 2});
    tbl.push_back('{1, 0,1,0,0, 6'b000101, 2});
    tbl.push_back('{12,0,0,0,0, 6'b111100, 3});
    tbl.push_back('{1, 0,0,0,1, 6'b011111, 3});
    tbl.push_back('{8, 0,0,0,0, 6'b000101, 3});  // in WK_ISO
    tbl.push_back('{1, 1,0,0,0, 6'b111100, 0});  // reset mid power-up

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].w, tbl[i].e);
      for (int j = 0; j < tbl[i].n; j++) step();
      chk($sformatf("tbl%0d_ctl", i), 32'(dut_vec(0)), 32'(tbl[i].exp));
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt_o[0]), 32'(tbl[i].c));
    end

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0);
      step();
    end

    drive(1, 0, 0, 0);
    step();
    for (int i = 0; i < 260; i++) begin
      drive(0, 0, 0, 1);
      step();
      drive(0, 0, 0, 0);
      for (int j = 0; j < 13; j++) step();
      drive(0, 1, 0, 0);
      step();
      drive(0, 0, 0, 0);
      for (int j = 0; j < 13; j++) step();
    end
    chk("sat_cnt_s4", 32'(cnt_o[0]), 32'd255);
    chk("sat_cnt_s0", 32'(cnt_o[1]), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbus_sleep_ctrl.md
# mbus_sleep_ctrl

Layer sleep controller: the power-gating sequencer that receives `SLEEP_REQUEST_TO_SLEEP_CTRL` from the bus controller wrapper and drives that wrapper's `RELEASE_RST_FROM_SLEEP_CTRL` input. It also drives the POWER_ON / RELEASE_CLK / RELEASE_ISO / RELEASE_RST controls of the gated layer domain. It runs an ordered, timed power-down sequence when sleep is requested and the reverse power-up sequence on a wake source. It sits in the always-on domain next to the bus controller.

## Interface
Parameters:
- STEP_CYCLES, 4: dwell, in CLK_EXT cycles, of every intermediate sequence state. Legal range 1–255; 0 behaves as 1.
- CNT_WIDTH, 8: width of SLEEP_COUNT.

Ports:
- CLK_EXT  in  1  always-on clock. One clock; reset is synchronous and active-high.
- RESET  in  1  synchronous, active-high reset.
- SLEEP_REQ  in  1  level sleep request from the bus controller.
- WAKEUP_REQ  in  1  level wake request (bus activity detect).
- EXTERNAL_INT  in  1  level external interrupt wake source.
- CLR_EXT_INT  out  1  one-cycle pulse that clears the interrupt source.
- POWER_ON  out  1  layer power switch: `IO_HOLD` = off, `IO_RELEASE` = on.
- RELEASE_CLK  out  1  layer clock gate.
- RELEASE_ISO  out  1  layer isolation.
- RELEASE_RST  out  1  layer reset, also driven to the wrapper's RELEASE_RST_FROM_SLEEP_CTRL.
- BUSY  out  1  high in any intermediate sequence state.
- SLEEP_COUNT  out  CNT_WIDTH  saturating count of completed power-downs.

## Operation
- States: ASLEEP, WK_PWR, WK_CLK, WK_ISO, AWAKE, SL_RST, SL_ISO, SL_CLK.
- All four control outputs are registered and use `IO_HOLD` / `IO_RELEASE` from mbus_def.v.
- Each output changes on the clock edge that enters the associated state:
  - entering WK_PWR releases POWER_ON;
  - entering WK_CLK releases RELEASE_CLK;
  - entering WK_ISO releases RELEASE_ISO;
  - entering AWAKE releases RELEASE_RST;
  - entering SL_RST holds RELEASE_RST;
  - entering SL_ISO holds RELEASE_ISO;
  - entering SL_CLK holds RELEASE_CLK;
  - entering ASLEEP holds POWER_ON.
- ASLEEP:
  - If WAKEUP_REQ | EXTERNAL_INT, go to WK_PWR and pulse CLR_EXT_INT for one cycle.
  - SLEEP_REQ is ignored in this state.
- WK_PWR → WK_CLK → WK_ISO → AWAKE. Each step is taken when the dwell counter expires.
- AWAKE:
  - If SLEEP_REQ & ~WAKEUP_REQ & ~EXTERNAL_INT, go to SL_RST.
  - Otherwise stay. A wake source takes priority over sleep.
- SL_RST → SL_ISO → SL_CLK → ASLEEP, each on counter expiry.
  - On entering ASLEEP, SLEEP_COUNT increments and saturates at all-ones.
- Sequences are never aborted.
  - SLEEP_REQ deasserting mid power-down has no effect.
  - A wake source arriving mid power-down is acted on in ASLEEP, the cycle after arrival there, if it is still asserted.
  - SLEEP_REQ arriving mid power-up is evaluated in AWAKE.
- Dwell counter:
  - 8-bit. Loaded with max(STEP_CYCLES,1)−1 on entry to each intermediate state.
  - Decrements each cycle; the state advances on the edge where the counter equals 0.
  - Loaded value is irrelevant in ASLEEP/AWAKE.
- BUSY = state ∉ {ASLEEP, AWAKE}, decoded from the state register with no extra latency.

## Timing
- Reset, sampled on the CLK_EXT edge while RESET=1:
  - state is ASLEEP;
  - POWER_ON, RELEASE_CLK, RELEASE_ISO and RELEASE_RST are all `IO_HOLD`;
  - CLR_EXT_INT=0, BUSY=0, SLEEP_COUNT=0, counter=0.
- Reset asserted mid-sequence forces the reset values on the next edge, whatever the current state or outputs.
- Wake latency: a wake source sampled high at edge n in ASLEEP gives:
  - POWER_ON released and CLR_EXT_INT=1 after edge n;
  - RELEASE_CLK after edge n+S;
  - RELEASE_ISO after edge n+2S;
  - RELEASE_RST after edge n+3S, with state AWAKE.
  - Here S = max(STEP_CYCLES,1).
- Sleep latency: SLEEP_REQ sampled at edge m in AWAKE gives:
  - RST held after edge m;
  - ISO held after edge m+S;
  - CLK held after edge m+2S;
  - POWER_ON held after edge m+3S, with SLEEP_COUNT incremented on that same edge.
- CLR_EXT_INT is exactly one cycle wide per ASLEEP exit.
- No output ever has two of its transitions fall on the same edge.
- The power-up order (PWR, CLK, ISO, RST) and power-down order (RST, ISO, CLK, PWR) are invariant.

## Test plan
- Reset, then hold RESET 3 cycles → all controls `IO_HOLD`, BUSY=0, SLEEP_COUNT=0, CLR_EXT_INT=0.
- STEP_CYCLES=4, pulse EXTERNAL_INT high 1 cycle in ASLEEP:
  - POWER_ON released at edge n, CLK at n+4, ISO at n+8, RST at n+12;
  - CLR_EXT_INT high exactly one cycle after edge n;
  - BUSY high for 12 cycles.
- From AWAKE, raise SLEEP_REQ:
  - RST held at m, ISO at m+4, CLK at m+8, POWER_ON at m+12;
  - SLEEP_COUNT 0→1.
- SLEEP_REQ and WAKEUP_REQ both high in AWAKE → stays AWAKE. Drop WAKEUP_REQ → power-down starts on the next edge.
- Assert WAKEUP_REQ at SL_ISO and hold it → power-down completes to ASLEEP (count increments), then WK_PWR is entered on the next edge.
- STEP_CYCLES=0 → behaves as 1, with 1-cycle steps. Also run 260 sleep cycles with CNT_WIDTH=8 → SLEEP_COUNT saturates at 255.
- RESET asserted during WK_ISO → next edge gives ASLEEP with all controls `IO_HOLD`.
